main_controller_multicycle: RTL
===============================

Name: main_controller_multicycle

Overview:
- Moore-style FSM that sequences the shared multicycle RV32I datapath: one unified memory port, one ALU, plus the IR, OldPC, A/B, Data and ALUOut registers.
- Drives all datapath enables and mux selects from the current state.
- Stalls on a memory ready handshake.
- Sits beside the ALU decoder, which turns ALUOp/Funct3/Funct7 into the ALU function. This block never decodes the ALU function itself.

Parameters:
- USE_MEM_READY, 1, when 0 mem_ready is ignored and treated as constant 1 (zero-wait memory).
- STATE_W, 4, width of the state register and state_o. Fixed at 4; all 16 encodings are used.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Opcode  in  7  IR[6:0], valid from DECODE onward.
- Funct3  in  3  IR[14:12], selects the branch condition.
- Comp  in  2  ALU flags: [0]=equal (zero), [1]=signed less-than.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  PC <= Result.
- AddrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR <= memory read data; OldPC <= PC.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  Result select: 00=ALUOut, 01=Data register, 10=ALU result.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=A register, 11=zero.
- ALUSrcB  out  2  ALU B select: 00=B register, 01=immediate, 10=constant 4.
- ALUOp  out  2  to the ALU decoder: 00=add, 01=sub (compare), 10=funct-decoded.
- illegal_op  out  1  sticky illegal-opcode flag.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset and defaults:
  - Async rst forces the state to FETCH(0).
  - While rst=1, all strobes are 0: PCWrite, MemRead, MemWrite, IRWrite, RegWrite, illegal_op, instr_done.
  - Selects and state_o show their FETCH values.
  - Any signal not listed for a state is 0.
- State encoding and per-state outputs, with the next state after "->":
  - FETCH(0): AddrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE, otherwise hold FETCH with request signals stable.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00, producing the branch/JAL target in ALUOut. Next state by Opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other opcode -> ILLEGAL
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Opcode[5]=0 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD(3): AddrSrc=1, MemRead=1. Hold until mem_ready, then -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
  - MEMWRITE(5): AddrSrc=1, MemWrite=1. Hold until mem_ready; instr_done=mem_ready. mem_ready=1 -> FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
  - BRANCH(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1 -> FETCH. PCWrite=taken, where taken is decided by Funct3:
    - 000: Comp[0]
    - 001: !Comp[0]
    - 100: Comp[1]
    - 101: !Comp[1]
    - any other Funct3: taken=0 and the instruction is treated as a no-op.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB. rd receives OldPC+4.
  - JALR(11): ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> JALRPC.
  - JALRPC(12): ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00 -> ALUWB.
  - LUI(13): ALUSrcA=11, ALUSrcB=01, ALUOp=00 -> ALUWB.
  - AUIPC(14): ALUSrcA=01, ALUSrcB=01, ALUOp=00 -> ALUWB.
  - ILLEGAL(15): all strobes 0, illegal_op=1. Absorbing state; only rst leaves it.
- Cycle counts with mem_ready always 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, LUI, AUIPC: 4 cycles.
  - JALR: 5 cycles.
  - branch: 3 cycles.
  - JAL: 4 cycles.
  - Each memory wait cycle adds exactly one cycle.
- Handshake rules:
  - Address, MemRead and MemWrite stay constant while waiting for mem_ready.
  - A mem_ready pulse outside FETCH, MEMREAD and MEMWRITE is ignored.
- Reset mid-access: the request drops immediately (asynchronously). No partial writeback occurs.

Decomposition:
- Shared package (the RISC-V defines file) holds:
  - opcode constants
  - state encodings
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings.
- One sub-module, branch_condition_unit (Funct3, Comp -> taken), which is combinational.
- The FSM itself is a single always block plus output decode.

Test Plan:
- Reset with rst=1 mid-MEMWRITE -> MemWrite=0 immediately, state_o=0, illegal_op=0.
- lw with mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 only in cycle 5; ResultSrc=01; instr_done pulse in cycle 5.
- sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 and AddrSrc=1 held 4 cycles; FETCH on the cycle after ready.
- beq: Comp=01 -> PCWrite=1 in BRANCH. Comp=00 -> PCWrite=0. bne with Comp=01 -> PCWrite=0. Funct3=010 -> PCWrite=0.
- JALR -> states 0,1,11,12,8; PCWrite=1 in FETCH and JALRPC only; RegWrite in ALUWB.
- Opcode 0000000 -> ILLEGAL, illegal_op=1 held for 20 cycles regardless of mem_ready; rst -> FETCH.

Source files
------------

// File: rtl/main_controller_multicycle_pkg.sv
// Shared RV32I defines for the multicycle controller: opcodes, state encodings,
// datapath select encodings and the DECODE dispatch helper.
`default_nettype none

package main_controller_multicycle_pkg;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Branch condition encodings (Funct3)
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALUSrcB
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  // First execute state for a freshly decoded opcode
  function automatic state_t decode_state(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_RTYPE:          return S_EXECR;
      OP_ITYPE:          return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_ILLEGAL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/main_controller_multicycle_branch_condition_unit.sv
// Combinational branch resolution from Funct3 and the ALU compare flags.
`default_nettype none

module branch_condition_unit
  import main_controller_multicycle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] comp,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = comp[0];
      F3_BNE:  taken = ~comp[0];
      F3_BLT:  taken = comp[1];
      F3_BGE:  taken = ~comp[1];
      default: taken = 1'b0;  // unsupported conditions behave as a no-op
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/main_controller_multicycle.sv
// Moore FSM sequencing the shared-memory multicycle RV32I datapath, with a
// memory-ready stall on FETCH, MEMREAD and MEMWRITE.
`default_nettype none

module main_controller_multicycle
  import main_controller_multicycle_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Opcode,
  input  logic [2:0]         Funct3,
  input  logic [1:0]         Comp,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AddrSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  state_t state;
  logic   ready;
  logic   taken;

  assign ready   = USE_MEM_READY ? mem_ready : 1'b1;
  assign state_o = state;

  branch_condition_unit u_branch_condition_unit (
    .funct3 (Funct3),
    .comp   (Comp),
    .taken  (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE:   state <= decode_state(Opcode);
        S_MEMADR:   state <= Opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_JALRPC;
        S_JALRPC:   state <= S_ALUWB;
        S_LUI:      state <= S_ALUWB;
        S_AUIPC:    state <= S_ALUWB;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_ILLEGAL;
      endcase
    end
  end

  // Output decode; strobes are forced low while rst is asserted so a reset
  // mid-access drops the memory request without waiting for a clock edge.
  always_comb begin
    PCWrite    = 1'b0;
    AddrSrc    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AddrSrc = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AddrSrc    = 1'b1;
        MemWrite   = 1'b1;
        instr_done = ready;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = taken;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE while the ALU forms OldPC+4
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_JALRPC: begin
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
        illegal_op = 1'b1;
      end
    endcase

    if (rst) begin
      PCWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

`default_nettype wire
